// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU pipeline type definitions.
//   Stall_t         - per-stage hold vector driven by pipeline_ctrl and
//                     consumed by every inter-stage pipeline register.
//   PipeCtrlState_t - pipeline_ctrl sequencing state.
package cpu_defs;

   typedef struct packed {
      logic stall_pc;
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mm;
      logic stall_wb;
   } Stall_t;

   typedef enum logic {
      PC_RUN,
      PC_MULTI
   } PipeCtrlState_t;

endpackage

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller.
//   Merges per-stage stall requests into a monotone Stall_t vector,
//   sequences multi-cycle EX operations, and aborts on exception flush.
//   It also keeps a saturating count of cycles in which the PC was held.
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   id_stall_req   in   load-use hazard from ID (same cycle)
//   ex_multi_start in   EX holds a multi-cycle op in its first cycle
//   mem_stall_req  in   MEM waiting on a bus response
//   flush_req      in   exception/eret from MEM, highest priority
//   stall          out  {pc,if,id,ex,mm,wb} hold vector (combinational)
//   flush          out  kill younger stages (equals flush_req)
//   ex_multi_done  out  pulse in the cycle the multi-cycle op leaves EX
//   stall_cycles   out  saturating count of cycles with stall_pc=1
module pipeline_ctrl
   import cpu_defs::*;
#(
   parameter int unsigned MULTI_CYCLES = 32,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_stall_req,
   input  logic             ex_multi_start,
   input  logic             mem_stall_req,
   input  logic             flush_req,
   output Stall_t           stall,
   output logic             flush,
   output logic             ex_multi_done,
   output logic [CNT_W-1:0] stall_cycles
);

   // The counter only ever holds MULTI_CYCLES-2 down to 0.
   localparam int unsigned CW = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES - 1) : 1;

   PipeCtrlState_t   r_state;
   PipeCtrlState_t   w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_ex_busy;
   logic [CNT_W-1:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PC_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_ex_busy     = 1'b0;
      ex_multi_done = 1'b0;
      stall         = '0;
      flush         = flush_req;

      case (r_state)
         PC_RUN: begin
            if (ex_multi_start) begin
               w_ex_busy   = 1'b1;
               w_state_nxt = PC_MULTI;
               w_cnt_nxt   = CW'(MULTI_CYCLES - 2);
            end
         end
         PC_MULTI: begin
            // The countdown runs independently of MEM; only the exit waits for it.
            if (r_cnt != '0) begin
               w_ex_busy = 1'b1;
               w_cnt_nxt = r_cnt - CW'(1);
            end else if (mem_stall_req) begin
               w_ex_busy = 1'b1;
            end else begin
               ex_multi_done = 1'b1;
               w_state_nxt   = PC_RUN;
            end
         end
         default: w_state_nxt = PC_RUN;
      endcase

      // Deepest requester sets the depth; earlier stages are always held too.
      if (mem_stall_req || w_ex_busy || id_stall_req) begin
         stall.stall_pc = 1'b1;
         stall.stall_if = 1'b1;
         stall.stall_id = 1'b1;
      end
      if (mem_stall_req || w_ex_busy) stall.stall_ex = 1'b1;
      if (mem_stall_req)              stall.stall_mm = 1'b1;

      if (flush_req) begin
         stall         = '0;
         ex_multi_done = 1'b0;
         w_state_nxt   = PC_RUN;
         w_cnt_nxt     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if (stall.stall_pc && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven check of pipeline_ctrl.
//   u_dut0: MULTI_CYCLES=32, CNT_W=32 (main sequencing table, reset mid-op).
//   u_dut1: MULTI_CYCLES=2,  CNT_W=4  (shortest op, counter saturation).
module tb_pipeline_ctrl;
   import cpu_defs::*;

   typedef struct {
      int unsigned rep;
      logic        id;
      logic        st;
      logic        mem;
      logic        fl;
      logic [5:0]  stall;
      logic        flush;
      logic        done;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, id0, st0, mem0, fl0;
   Stall_t      s0;
   logic        f0, d0;
   logic [31:0] sc0;

   logic        rst1, id1, st1, mem1, fl1;
   Stall_t      s1;
   logic        f1, d1;
   logic [3:0]  sc1;

   pipeline_ctrl #(.MULTI_CYCLES(32), .CNT_W(32)) u_dut0 (
      .clk(clk), .rst(rst0), .id_stall_req(id0), .ex_multi_start(st0),
      .mem_stall_req(mem0), .flush_req(fl0), .stall(s0), .flush(f0),
      .ex_multi_done(d0), .stall_cycles(sc0)
   );

   pipeline_ctrl #(.MULTI_CYCLES(2), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst1), .id_stall_req(id1), .ex_multi_start(st1),
      .mem_stall_req(mem1), .flush_req(fl1), .stall(s1), .flush(f1),
      .ex_multi_done(d1), .stall_cycles(sc1)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   vec_t v0[$];
   vec_t v1[$];

   function automatic vec_t mk(int unsigned rep, logic id, logic st, logic mem, logic fl,
                               logic [5:0] s, logic f, logic d);
      vec_t v;
      v.rep = rep; v.id = id; v.st = st; v.mem = mem; v.fl = fl;
      v.stall = s; v.flush = f; v.done = d;
      return v;
   endfunction

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_ID   = 6'b111000;
   localparam logic [5:0] S_EX   = 6'b111100;
   localparam logic [5:0] S_MEM  = 6'b111110;

   int unsigned exp_sc0;
   int unsigned exp_sc1;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //            rep id st mem fl  stall   fl dn
      v0.push_back(mk( 2, 0, 0, 0, 0, S_NONE, 0, 0));  // idle
      v0.push_back(mk( 1, 1, 0, 0, 0, S_ID,   0, 0));  // load-use bubble
      v0.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 0));
      v0.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // op A, cycle 0
      v0.push_back(mk(30, 0, 0, 0, 0, S_EX,   0, 0));  // cycles 1..30
      v0.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 1));  // cycle 31: done
      v0.push_back(mk( 2, 0, 0, 0, 0, S_NONE, 0, 0));  // back in RUN
      v0.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // op B, cycle 0
      v0.push_back(mk(28, 0, 0, 0, 0, S_EX,   0, 0));  // cycles 1..28
      v0.push_back(mk( 7, 0, 0, 1, 0, S_MEM,  0, 0));  // cycles 29..35 mem stall
      v0.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 1));  // cycle 36: done
      v0.push_back(mk( 2, 0, 0, 0, 0, S_NONE, 0, 0));  // no second pulse
      v0.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // op C, cycle 0
      v0.push_back(mk( 9, 0, 0, 0, 0, S_EX,   0, 0));  // cycles 1..9
      v0.push_back(mk( 1, 1, 0, 0, 1, S_NONE, 1, 0));  // cycle 10: flush wins
      v0.push_back(mk(25, 0, 0, 0, 0, S_NONE, 0, 0));  // aborted: no done
      v0.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // op D, start held high
      v0.push_back(mk(30, 0, 1, 0, 0, S_EX,   0, 0));  // restart ignored in MULTI
      v0.push_back(mk( 1, 0, 1, 0, 0, S_NONE, 0, 1));  // done despite start
      v0.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // new op from RUN
      v0.push_back(mk( 1, 0, 0, 1, 1, S_NONE, 1, 0));  // flush beats mem
      v0.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 0));
      v0.push_back(mk( 1, 1, 1, 0, 0, S_EX,   0, 0));  // id+start: EX deepest
      v0.push_back(mk( 1, 0, 0, 0, 1, S_NONE, 1, 0));  // abort
      v0.push_back(mk( 1, 1, 0, 1, 0, S_MEM,  0, 0));  // id+mem: MEM deepest
      v0.push_back(mk( 1, 0, 1, 0, 1, S_NONE, 1, 0));  // start with flush: no op
      v0.push_back(mk( 2, 0, 0, 0, 0, S_NONE, 0, 0));

      v1.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // 2-cycle op
      v1.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 1));
      v1.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 0));
      v1.push_back(mk( 1, 0, 1, 0, 0, S_EX,   0, 0));  // done held by MEM at cnt 0
      v1.push_back(mk( 2, 0, 0, 1, 0, S_MEM,  0, 0));
      v1.push_back(mk( 1, 0, 0, 0, 0, S_NONE, 0, 1));
      v1.push_back(mk(20, 1, 0, 0, 0, S_ID,   0, 0));  // drive counter to saturation
      v1.push_back(mk( 2, 0, 0, 0, 0, S_NONE, 0, 0));

      rst0 = 1'b1; id0 = 0; st0 = 0; mem0 = 0; fl0 = 0;
      rst1 = 1'b1; id1 = 0; st1 = 0; mem1 = 0; fl1 = 0;
      exp_sc0 = 0; exp_sc1 = 0;

      repeat (2) @(negedge clk);
      #1;
      chk("reset_stall", 32'(s0), 32'(S_NONE));
      chk("reset_flush", 32'(f0), 32'd0);
      chk("reset_sc",    sc0,     32'd0);
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;

      for (int i = 0; i < v0.size(); i++) begin
         for (int unsigned r = 0; r < v0[i].rep; r++) begin
            @(negedge clk);
            id0 = v0[i].id; st0 = v0[i].st; mem0 = v0[i].mem; fl0 = v0[i].fl;
            #1;
            chk($sformatf("d0_v%0d_stall", i), 32'(s0), 32'(v0[i].stall));
            chk($sformatf("d0_v%0d_flush", i), 32'(f0), 32'(v0[i].flush));
            chk($sformatf("d0_v%0d_done",  i), 32'(d0), 32'(v0[i].done));
            chk($sformatf("d0_v%0d_sc",    i), sc0,     exp_sc0);
            if (v0[i].stall[5]) exp_sc0++;
         end
      end

      for (int i = 0; i < v1.size(); i++) begin
         for (int unsigned r = 0; r < v1[i].rep; r++) begin
            @(negedge clk);
            id1 = v1[i].id; st1 = v1[i].st; mem1 = v1[i].mem; fl1 = v1[i].fl;
            #1;
            chk($sformatf("d1_v%0d_stall", i), 32'(s1), 32'(v1[i].stall));
            chk($sformatf("d1_v%0d_flush", i), 32'(f1), 32'(v1[i].flush));
            chk($sformatf("d1_v%0d_done",  i), 32'(d1), 32'(v1[i].done));
            chk($sformatf("d1_v%0d_sc",    i), 32'(sc1), exp_sc1);
            if (v1[i].stall[5] && exp_sc1 < 15) exp_sc1++;
         end
      end
      chk("d1_sc_saturated", 32'(sc1), 32'd15);

      // Asynchronous reset in the middle of a multi-cycle op.
      @(negedge clk);
      st0 = 1'b1; id0 = 0; mem0 = 0; fl0 = 0;
      @(negedge clk);
      st0 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("midop_stall", 32'(s0), 32'(S_EX));
      rst0 = 1'b1;
      #1;
      chk("async_rst_stall", 32'(s0), 32'(S_NONE));
      chk("async_rst_done",  32'(d0), 32'd0);
      chk("async_rst_sc",    sc0,     32'd0);
      @(negedge clk);
      rst0 = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_stall", 32'(s0), 32'(S_NONE));
      chk("post_rst_sc",    sc0,     32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush controller; the producer of the Stall_t vector consumed by every inter-stage pipeline register (if_id, id_ex, ex_mem, mem_wb).
- Merges per-stage stall requests, sequences multi-cycle EX operations (mult/div) with an internal cycle counter, and aborts everything on an exception flush.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULTI_CYCLES, 32, EX-stage cycles a multi-cycle op occupies, including the start cycle; legal range 2..64.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_stall_req  in  1  load-use hazard from ID; combinational, same cycle
- ex_multi_start  in  1  EX holds a multi-cycle op in its first cycle; ignored unless state is RUN
- mem_stall_req  in  1  MEM waiting on a bus response
- flush_req  in  1  exception/eret from MEM; highest priority
- stall  out  Stall_t  {stall_pc, stall_if, stall_id, stall_ex, stall_mm, stall_wb}; combinational
- flush  out  1  kill all younger stages; equals flush_req
- ex_multi_done  out  1  one-cycle pulse in the cycle the multi-cycle op leaves EX
- stall_cycles  out  CNT_W  cycles with stall_pc=1; saturates at all-ones

Behaviour:
- Stall semantics:
  - stall_X=1 means stage X holds its register.
  - stall_X=1 with stall_X+1=0 makes the downstream register load a bubble.
  - The vector is monotone: if stall_X=1 then every earlier stage bit is also 1.
- Requested depth, deepest requester wins:
  - mem_stall_req -> pc..mm
  - EX busy -> pc..ex
  - id_stall_req -> pc..id
  - none -> all 0
  - stall_wb is always 0.
- EX busy = (state==RUN && ex_multi_start) || state==MULTI.
- flush_req=1 forces all stall bits 0 and flush=1 that cycle, regardless of other requests.
- FSM states: RUN, MULTI.
  - RUN -> MULTI: ex_multi_start && !flush_req. Load cnt = MULTI_CYCLES-2.
  - MULTI, cnt>0: cnt decrements every cycle, regardless of mem_stall_req.
  - MULTI, cnt==0 && !mem_stall_req: EX busy deasserts this cycle, ex_multi_done=1, next state RUN.
  - MULTI, cnt==0 && mem_stall_req: stay in MULTI with cnt held at 0; ex_multi_done stays 0 until the first cycle mem_stall_req is low.
  - Any state, flush_req: next state RUN, cnt=0, ex_multi_done=0 (aborted op produces no done pulse).
- Latency: from a start cycle with no mem stall, EX is held for exactly MULTI_CYCLES cycles. ex_multi_done asserts in the last of them, with stall_ex=0.
- stall_cycles:
  - Increments at the clock edge after any cycle with stall_pc=1.
  - Holds at 2^CNT_W-1.
  - Not cleared by flush.
- Reset (asynchronous, takes effect immediately, mid-operation included): state=RUN, cnt=0, stall_cycles=0. Outputs then follow the combinational rules with state RUN (all 0 when inputs are 0).
- ex_multi_start while in MULTI is ignored; EX is already frozen holding the same op.

Decomposition:
- Shared cpu_defs package:
  - Stall_t packed struct (field order above); already owned there, not redefined.
  - PipeCtrlState_t enum {PC_RUN, PC_MULTI}.
- No sub-module. The saturating counter is a few lines inline.

Test Plan:
- Idle, all inputs 0 after reset -> stall all 0, flush=0, stall_cycles=0.
- id_stall_req=1 for one cycle -> stall_pc/if/id=1, stall_ex=0 (ID->EX bubble); stall_cycles becomes 1 the next cycle.
- ex_multi_start=1 at cycle 0, MULTI_CYCLES=32 -> stall_ex=1 for cycles 0..30; cycle 31 stall_ex=0 and ex_multi_done=1; state RUN at cycle 32.
- Multi-cycle op with mem_stall_req=1 over cycles 29..35 -> stall_mm=1 in 29..35; done withheld, then ex_multi_done=1 and stall_ex=0 at cycle 36; no second pulse.
- flush_req=1 at cycle 10 of a multi-cycle op, with id_stall_req=1 -> that cycle stall=0 and flush=1; state RUN next; ex_multi_done never pulses.
- Force stall_cycles to all-ones (CNT_W=4 build) with continuous stall -> holds at 15. Assert rst mid-MULTI -> outputs drop to 0 without waiting for a clock edge.
